// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and helpers for the mult/div unit
package mult_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_PA   = 3'd1,
        SEL_P2A  = 3'd2,
        SEL_MA   = 3'd3,
        SEL_M2A  = 3'd4
    } booth_sel_t;

    // Radix-4 recoding of the window {b[i+1], b[i], b[i-1]}.
    function automatic booth_sel_t booth_decode(input logic [2:0] window);
        booth_sel_t sel;
        case (window)
            3'b001, 3'b010: sel = SEL_PA;
            3'b011:         sel = SEL_P2A;
            3'b100:         sel = SEL_M2A;
            3'b101, 3'b110: sel = SEL_MA;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

    function automatic int iter_count(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// rtl/booth_r4_sel.sv - radix-4 Booth addend selector (0, +/-A, +/-2A)
module booth_r4_sel
    import mult_div_pkg::*;
#(
    parameter int E = 34
) (
    input  logic [2:0]   i_window,
    input  logic [E-1:0] i_a,
    output logic [E+1:0] o_addend
);

    logic [E+1:0] w_a_ext;

    assign w_a_ext = {{2{i_a[E-1]}}, i_a};

    always_comb begin
        o_addend = '0;
        case (booth_decode(i_window))
            SEL_PA:  o_addend = w_a_ext;
            SEL_P2A: o_addend = w_a_ext << 1;
            SEL_MA:  o_addend = -w_a_ext;
            SEL_M2A: o_addend = -(w_a_ext << 1);
            default: o_addend = '0;
        endcase
    end

endmodule

// File: rtl/mult_booth_param.sv
// rtl/mult_booth_param.sv - multicycle radix-4 Booth multiplier, signed/unsigned, full product
module mult_booth_param
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int E     = WIDTH + 2;
    localparam int N     = iter_count(WIDTH);
    localparam int CNT_W = $clog2(N + 1);
    localparam int PW    = 2 * E + 1;

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
            $error("mult_booth_param: WIDTH must be even and >= 4");
        end
    endgenerate

    md_state_t        r_state;
    md_state_t        w_next_state;
    logic [E-1:0]     r_a;
    logic [PW-1:0]    r_p;
    logic [CNT_W-1:0] r_count;
    logic             r_signed;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_exc;
    logic             r_rdy;
    logic             r_busy;

    logic [E-1:0]     w_ext_a;
    logic [E-1:0]     w_ext_b;
    logic [E+1:0]     w_addend;
    logic [E+1:0]     w_sum;
    logic [PW-1:0]    w_p_next;
    logic             w_last;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_exc;
    logic             w_unused;

    assign w_ext_a = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    assign w_ext_b = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};

    booth_r4_sel #(.E(E)) u_sel (
        .i_window (r_p[2:0]),
        .i_a      (r_a),
        .o_addend (w_addend)
    );

    // Two guard bits absorb the +/-2A addend before the arithmetic shift.
    assign w_sum    = {{2{r_p[PW-1]}}, r_p[PW-1:E+1]} + w_addend;
    assign w_p_next = {w_sum, r_p[E:2]};
    assign w_last   = (r_state == ST_RUN) && (r_count == CNT_W'(N - 1));
    assign w_lo     = w_p_next[WIDTH:1];
    assign w_hi     = w_p_next[2*WIDTH:WIDTH+1];
    assign w_exc    = r_signed ? (w_hi != {WIDTH{w_lo[WIDTH-1]}})
                               : (w_hi != {WIDTH{1'b0}});
    assign w_unused = ^{w_p_next[PW-1:2*WIDTH+1], w_p_next[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (ctrl_MULT) w_next_state = ST_RUN;
            ST_RUN: begin
                if (ctrl_MULT)   w_next_state = ST_RUN;
                else if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: if (ctrl_MULT) w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_p      <= '0;
            r_count  <= '0;
            r_signed <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (ctrl_MULT) begin
            // A new start always wins, including an abort of a running operation.
            r_a      <= w_ext_a;
            r_p      <= {{E{1'b0}}, w_ext_b, 1'b0};
            r_count  <= '0;
            r_signed <= is_signed;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_p     <= w_p_next;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
                r_lo   <= w_lo;
                r_hi   <= w_hi;
                r_exc  <= w_exc;
                r_rdy  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign data_result    = r_lo;
    assign data_result_hi = r_hi;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_mult_booth_param.sv
// tb/tb_mult_booth_param.sv - directed bench for mult_booth_param (WIDTH 32 and 8)
module tb_mult_booth_param;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        ctrl32, sgn32;
    logic [31:0] a32, b32, lo32, hi32;
    logic        exc32, rdy32, busy32;

    logic        ctrl8, sgn8;
    logic [7:0]  a8, b8, lo8, hi8;
    logic        exc8, rdy8, busy8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_booth_param #(.WIDTH(32)) u_dut32 (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl32),
        .is_signed      (sgn32),
        .multiplicand   (a32),
        .multiplier     (b32),
        .data_result    (lo32),
        .data_result_hi (hi32),
        .data_exception (exc32),
        .data_resultRDY (rdy32),
        .busy           (busy32)
    );

    mult_booth_param #(.WIDTH(8)) u_dut8 (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl8),
        .is_signed      (sgn8),
        .multiplicand   (a8),
        .multiplier     (b8),
        .data_result    (lo8),
        .data_result_hi (hi8),
        .data_exception (exc8),
        .data_resultRDY (rdy8),
        .busy           (busy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        a32 = a; b32 = b; sgn32 = s; ctrl32 = 1'b1;
        @(negedge clk);
        ctrl32 = 1'b0; a32 = $urandom; b32 = $urandom; sgn32 = ~s;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        a8 = a; b8 = b; sgn8 = s; ctrl8 = 1'b1;
        @(negedge clk);
        ctrl8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    endtask

    task automatic wait_rdy32(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rdy32) begin cyc = i; break; end
        end
    endtask

    task automatic wait_rdy8(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rdy8) begin cyc = i; break; end
        end
    endtask

    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_exc);
        int cyc;
        start32(a, b, s);
        check({tag, " busy_at_start"}, 64'(busy32), 64'd1);
        check({tag, " rdy_at_start"},  64'(rdy32),  64'd0);
        check({tag, " exc_at_start"},  64'(exc32),  64'd0);
        wait_rdy32(cyc);
        check({tag, " latency"}, 64'(cyc),     64'd17);
        check({tag, " lo"},      64'(lo32),    64'(exp_lo));
        check({tag, " hi"},      64'(hi32),    64'(exp_hi));
        check({tag, " exc"},     64'(exc32),   64'(exp_exc));
        check({tag, " busy_done"}, 64'(busy32), 64'd0);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] exp_lo, input logic [7:0] exp_hi, input logic exp_exc);
        int cyc;
        start8(a, b, s);
        wait_rdy8(cyc);
        check({tag, " latency"}, 64'(cyc),  64'd5);
        check({tag, " lo"},      64'(lo8),  64'(exp_lo));
        check({tag, " hi"},      64'(hi8),  64'(exp_hi));
        check({tag, " exc"},     64'(exc8), 64'(exp_exc));
    endtask

    initial begin
        logic        seen;
        int          cyc;
        logic [7:0]  ra, rb;
        logic        rs;
        int          pa, pb, pr;
        logic [15:0] p16;
        logic        pexc;

        reset_n = 1'b0;
        ctrl32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        ctrl8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset rdy",  64'(rdy32),  64'd0);
        check("reset lo",   64'(lo32),   64'd0);
        check("reset hi",   64'(hi32),   64'd0);
        check("reset exc",  64'(exc32),  64'd0);
        reset_n = 1'b1;

        // 1: asynchronous reset in the middle of a run
        start32(32'd5, 32'd6, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy32), 64'd0);
        check("midreset rdy",  64'(rdy32),  64'd0);
        check("midreset lo",   64'(lo32),   64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            seen = seen | rdy32 | busy32;
        end
        check("midreset no_rdy_after", 64'(seen), 64'd0);

        // 2..4: signed/unsigned corner products
        op32("s_m3x7", 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("hold rdy", 64'(rdy32), 64'd1);
        check("hold lo",  64'(lo32),  64'hFFFFFFEB);
        op32("u_max_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b1);
        op32("s_m1_sq",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'h00000000, 1'b0);
        op32("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000, 1'b1);
        op32("s_zero",   32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000, 1'b0);

        // 5: restart while busy
        start32(32'd2, 32'd3, 1'b0);
        seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            seen = seen | rdy32;
        end
        start32(32'd5, 32'd5, 1'b0);
        check("restart busy", 64'(busy32), 64'd1);
        wait_rdy32(cyc);
        check("restart latency", 64'(cyc),  64'd17);
        check("restart lo",      64'(lo32), 64'd25);
        check("restart hi",      64'(hi32), 64'd0);
        check("restart no_early_rdy", 64'(seen), 64'd0);

        // 6: narrow instance, directed then random against a reference model
        op8("w8_200sq", 8'd200, 8'd200, 1'b0, 8'h40, 8'h9C, 1'b1);
        op8("w8_s_m128sq", 8'h80, 8'h80, 1'b1, 8'h00, 8'h40, 1'b1);
        op8("w8_s_m1x5", 8'hFF, 8'h05, 1'b1, 8'hFB, 8'hFF, 1'b0);
        for (int k = 0; k < 12; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            pa = rs ? int'($signed(ra)) : int'(ra);
            pb = rs ? int'($signed(rb)) : int'(rb);
            pr = pa * pb;
            p16 = pr[15:0];
            pexc = rs ? (pr < -128 || pr > 127) : (pr > 255);
            op8($sformatf("w8_rand%0d", k), ra, rb, rs, p16[7:0], p16[15:8], pexc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
